// File: rtl/player_cmd_sched_pkg.sv
// Package shared by the player command scheduler, the Player datapath and the
// top level.
//   - Default frame divider and defend budget values.
//   - Defend FSM state type.
//   - Small helper for sizing counters.
package player_cmd_sched_pkg;

  // 60 Hz frame steps from a 50 MHz system clock.
  localparam int unsigned FRAME_DIV_DFLT = 833_333;
  localparam int unsigned DEF_MAX_DFLT   = 30;
  localparam int unsigned DEF_COOL_DFLT  = 60;

  typedef enum logic [1:0] {
    DEF_READY  = 2'd0,
    DEF_ACTIVE = 2'd1,
    DEF_COOL   = 2'd2
  } def_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/player_cmd_sched_frame.sv
// frame_tick: free-running divider that raises tick for one cycle every DIV
// clock cycles. Also used by the renderer's animation timer.
//   clk  in  : system clock
//   rst  in  : asynchronous active-high reset
//   tick out : high in the cycle where the counter sits at DIV-1
module frame_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LastCnt = W'(DIV - 1);

  logic [W-1:0] fcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q <= '0;
    end else if (fcnt_q == LastCnt) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign tick = (fcnt_q == LastCnt);

endmodule

// File: rtl/player_cmd_sched.sv
// player_cmd_sched: per-player command scheduler. Collects button activity
// over a frame, resolves conflicts, applies the defend duration/cooldown
// budget and emits one cycle of cleaned commands alongside a step enable.
//   clk, rst                         : system clock, async active-high reset
//   key_right/left/jump/squat/defend : synchronised button levels
//   step                             : one-cycle frame pulse (Player enable)
//   right/left/jump/squat/defend     : resolved commands, valid with step only
//   def_ready                        : defend FSM is READY (HUD)
module player_cmd_sched #(
  parameter int unsigned FRAME_DIV = player_cmd_sched_pkg::FRAME_DIV_DFLT,
  parameter int unsigned DEF_MAX   = player_cmd_sched_pkg::DEF_MAX_DFLT,
  parameter int unsigned DEF_COOL  = player_cmd_sched_pkg::DEF_COOL_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_right,
  input  logic key_left,
  input  logic key_jump,
  input  logic key_squat,
  input  logic key_defend,
  output logic step,
  output logic right,
  output logic left,
  output logic jump,
  output logic squat,
  output logic defend,
  output logic def_ready
);

  import player_cmd_sched_pkg::*;

  localparam int unsigned DW = $clog2(max_u(DEF_MAX, DEF_COOL) + 1);
  localparam logic [DW-1:0] DMaxC   = DW'(DEF_MAX);
  localparam logic [DW-1:0] DCoolC  = DW'(DEF_COOL);
  localparam logic [DW-1:0] DCoolM1 = DW'(DEF_COOL - 1);

  // Bit order: 0 right, 1 left, 2 jump, 3 squat, 4 defend.
  logic [4:0] keys;
  logic [4:0] lat_q;
  logic [4:0] acc;
  logic       step_cycle;
  logic       prev_jump_q;

  player_cmd_sched_pkg::def_state_e def_st_q, def_st_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic active_nx;
  logic right_c, left_c, jump_c, squat_c;

  frame_tick #(
    .DIV (FRAME_DIV)
  ) u_frame_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (step_cycle)
  );

  assign keys = {key_defend, key_squat, key_jump, key_left, key_right};
  // Step-cycle sample is folded in so a press in that cycle is not lost.
  assign acc  = lat_q | keys;

  always_comb begin
    def_st_d = def_st_q;
    dcnt_d   = dcnt_q;
    case (def_st_q)
      player_cmd_sched_pkg::DEF_READY: begin
        if (acc[4]) begin
          def_st_d = player_cmd_sched_pkg::DEF_ACTIVE;
          dcnt_d   = DW'(1);
        end
      end
      player_cmd_sched_pkg::DEF_ACTIVE: begin
        if (!acc[4] || (dcnt_q == DMaxC)) begin
          def_st_d = player_cmd_sched_pkg::DEF_COOL;
          dcnt_d   = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      player_cmd_sched_pkg::DEF_COOL: begin
        // Saturates so a long hold cannot wrap the counter.
        if (dcnt_q < DCoolC) begin
          dcnt_d = dcnt_q + 1'b1;
        end
        if ((dcnt_q >= DCoolM1) && !acc[4]) begin
          def_st_d = player_cmd_sched_pkg::DEF_READY;
          dcnt_d   = '0;
        end
      end
      default: begin
        def_st_d = player_cmd_sched_pkg::DEF_READY;
        dcnt_d   = '0;
      end
    endcase
  end

  // Blocking uses the state after this step's transition, matching defend.
  assign active_nx = (def_st_d == player_cmd_sched_pkg::DEF_ACTIVE);
  assign right_c   = acc[0] & ~acc[1] & ~active_nx;
  assign left_c    = acc[1] & ~acc[0] & ~active_nx;
  assign jump_c    = acc[2] & ~prev_jump_q & ~active_nx;
  assign squat_c   = acc[3] & ~jump_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q       <= '0;
      prev_jump_q <= 1'b0;
      def_st_q    <= player_cmd_sched_pkg::DEF_READY;
      dcnt_q      <= '0;
      step        <= 1'b0;
      right       <= 1'b0;
      left        <= 1'b0;
      jump        <= 1'b0;
      squat       <= 1'b0;
      defend      <= 1'b0;
    end else begin
      step   <= step_cycle;
      right  <= step_cycle & right_c;
      left   <= step_cycle & left_c;
      jump   <= step_cycle & jump_c;
      squat  <= step_cycle & squat_c;
      defend <= step_cycle & active_nx;
      if (step_cycle) begin
        lat_q       <= '0;
        prev_jump_q <= acc[2];
        def_st_q    <= def_st_d;
        dcnt_q      <= dcnt_d;
      end else begin
        lat_q <= acc;
      end
    end
  end

  assign def_ready = (def_st_q == player_cmd_sched_pkg::DEF_READY);

endmodule

// File: tb/tb_player_cmd_sched.sv
// Self-checking bench for player_cmd_sched with FRAME_DIV=4, DEF_MAX=3,
// DEF_COOL=2. A frame-level behavioural model predicts every output each
// cycle; directed frames pin both the DUT and the model to literal values,
// followed by randomized key activity with occasional mid-frame resets.
module tb_player_cmd_sched;

  localparam int FD = 4;
  localparam int DM = 3;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_right = 1'b0, key_left = 1'b0, key_jump = 1'b0, key_squat = 1'b0;
  logic key_defend = 1'b0;
  logic step, right, left, jump, squat, defend, def_ready;

  player_cmd_sched #(
    .FRAME_DIV (FD),
    .DEF_MAX   (DM),
    .DEF_COOL  (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_right  (key_right),
    .key_left   (key_left),
    .key_jump   (key_jump),
    .key_squat  (key_squat),
    .key_defend (key_defend),
    .step       (step),
    .right      (right),
    .left       (left),
    .jump       (jump),
    .squat      (squat),
    .defend     (defend),
    .def_ready  (def_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: cycles into the frame, keys seen this frame, last frame's
  // jump, and the defend budget as "frames defended" / "frames cooled".
  int       ph;
  bit [4:0] seen;
  bit       last_jump;
  bit       defending, cooling;
  int       def_frames, cool_frames;
  bit       e_step, e_r, e_l, e_j, e_s, e_d;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit e_ready();
    return !defending && !cooling;
  endfunction

  task automatic model_reset();
    ph = 0; seen = '0; last_jump = 0;
    defending = 0; cooling = 0; def_frames = 0; cool_frames = 0;
    {e_step, e_r, e_l, e_j, e_s, e_d} = '0;
  endtask

  task automatic model_edge(input bit [4:0] k);
    bit [4:0] all;
    all = seen | k;
    {e_step, e_r, e_l, e_j, e_s, e_d} = '0;
    if (ph == FD - 1) begin
      if (defending) begin
        if (!all[4] || def_frames == DM) begin
          defending = 0; cooling = 1; cool_frames = 0;
        end else begin
          def_frames++;
        end
      end else if (cooling) begin
        // Lockout ends once DC cooling frames have passed and the key is up.
        if (cool_frames + 1 >= DC && !all[4]) cooling = 0;
        else cool_frames++;
      end else if (all[4]) begin
        defending = 1; def_frames = 1;
      end
      e_step = 1;
      e_d    = defending;
      e_r    = all[0] && !all[1] && !defending;
      e_l    = all[1] && !all[0] && !defending;
      e_j    = all[2] && !last_jump && !defending;
      e_s    = all[3] && !e_j;
      last_jump = all[2];
      seen = '0;
    end else begin
      seen = all;
    end
    ph = (ph + 1) % FD;
  endtask

  task automatic compare_all();
    chk("step", step, e_step);
    chk("right", right, e_r);
    chk("left", left, e_l);
    chk("jump", jump, e_j);
    chk("squat", squat, e_s);
    chk("defend", defend, e_d);
    chk("def_ready", def_ready, e_ready());
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic run_cycle(input bit [4:0] k);
    {key_defend, key_squat, key_jump, key_left, key_right} = k;
    @(posedge clk);
    model_edge(k);
    @(negedge clk);
    compare_all();
  endtask

  // One aligned frame; the last cycle must be the step cycle.
  task automatic frame(input bit [4:0] k0, input bit [4:0] k1,
                       input bit [4:0] k2, input bit [4:0] k3);
    run_cycle(k0); run_cycle(k1); run_cycle(k2); run_cycle(k3);
    chk("frame_step_lit", step, 1'b1);
  endtask

  task automatic do_reset();
    {key_defend, key_squat, key_jump, key_left, key_right} = '0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_step", step, 1'b0);
    chk("rst_cmds", right | left | jump | squat | defend, 1'b0);
    chk("rst_ready", def_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  localparam bit [4:0] R = 5'b00001, L = 5'b00010, J = 5'b00100;
  localparam bit [4:0] S = 5'b01000, D = 5'b10000, Z = 5'b00000;

  initial begin
    bit [4:0] kr;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    chk("init_ready", def_ready, 1'b1);

    // Idle: steps at cycles 4, 8, 12 after release.
    for (int c = 1; c <= 12; c++) begin
      run_cycle(Z);
      chk("idle_step_lit", step, (c % FD) == 0);
      chk("idle_ready_lit", def_ready, 1'b1);
    end

    // Short right pulse mid-frame, then it must not repeat.
    frame(Z, R, Z, Z);
    chk("pulse_right_lit", right, 1'b1);
    chk("pulse_model_lit", e_r, 1'b1);
    frame(Z, Z, Z, Z);
    chk("pulse_gone_lit", right, 1'b0);
    // Press only in the step cycle itself.
    frame(Z, Z, Z, L);
    chk("stepcyc_left_lit", left, 1'b1);
    // Conflict.
    frame(R, Z, L, Z);
    chk("conflict_r_lit", right, 1'b0);
    chk("conflict_l_lit", left, 1'b0);

    // Held jump jumps once.
    frame(J, J, J, J);
    chk("jump1_lit", jump, 1'b1);
    frame(J, J, J, J);
    chk("jump2_lit", jump, 1'b0);
    frame(J, J, J, J);
    chk("jump3_lit", jump, 1'b0);
    frame(Z, Z, Z, Z);
    frame(J | S, Z, Z, Z);
    chk("js_jump_lit", jump, 1'b1);
    chk("js_squat_lit", squat, 1'b0);
    chk("js_model_lit", e_s, 1'b0);

    // Defend budget with right held: 3 active frames, then cooldown.
    for (int f = 0; f < 3; f++) begin
      frame(D | R, D | R, D | R, D | R);
      chk("def_on_lit", defend, 1'b1);
      chk("def_blocks_right_lit", right, 1'b0);
      chk("def_model_lit", e_d, 1'b1);
    end
    frame(D | R, D | R, D | R, D | R);
    chk("cool_def_lit", defend, 1'b0);
    chk("cool_right_lit", right, 1'b1);
    chk("cool_ready_lit", def_ready, 1'b0);
    frame(D, D, D, D);
    chk("cool_held_lit", def_ready, 1'b0);
    chk("cool_held_def_lit", defend, 1'b0);
    frame(Z, Z, Z, Z);
    chk("ready_again_lit", def_ready, 1'b1);
    chk("ready_model_lit", e_ready(), 1'b1);

    // Reset during ACTIVE with right latched.
    frame(D, D, D, D);
    chk("pre_rst_active_lit", defend, 1'b1);
    run_cycle(R);
    run_cycle(R);
    do_reset();
    frame(Z, Z, Z, Z);
    chk("post_rst_right_lit", right, 1'b0);
    chk("post_rst_ready_lit", def_ready, 1'b1);

    // Randomized activity with sticky-ish keys and rare resets.
    kr = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 5) == 0) kr[b] = ~kr[b];
      if ($urandom_range(0, 7) == 0) kr[0] = ~kr[0];
      if ($urandom_range(0, 299) == 0) do_reset();
      else run_cycle(kr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/player_cmd_sched.md
# player_cmd_sched

Per-player command scheduler between the raw button inputs and the `Player` position/jump datapath. It divides the system clock into frame steps and collects button activity between steps. At each step it resolves conflicting buttons and enforces a defend duration/cooldown budget. It then presents one cycle of cleaned `right/left/jump/squat/defend` commands together with a `step` clock-enable that the `Player` instance qualifies its register updates with.

## Interface
- `FRAME_DIV`, 833_333: clock cycles per frame step (60 Hz at 50 MHz); legal range ≥ 2.
- `DEF_MAX`, 30: maximum consecutive frames defend may stay active; legal range ≥ 1.
- `DEF_COOL`, 60: frames defend is locked out after an active period ends; legal range ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `key_right`, `key_left`, `key_jump`, `key_squat`, `key_defend` in 1 each: button levels, already synchronised to `clk`.
- `step` out 1: one-cycle frame pulse; `Player` clock-enable.
- `right`, `left`, `jump`, `squat`, `defend` out 1 each: resolved commands, meaningful only while `step`=1, 0 otherwise.
- `def_ready` out 1: defend FSM is in READY (HUD indicator).

## Operation
- **Frame divider.** `fcnt` counts 0..FRAME_DIV-1 and wraps. The step cycle is the cycle in which `fcnt`==FRAME_DIV-1.
- **Sticky latches.** Each `key_*` is OR-accumulated into `lat_*` every cycle. The step cycle's own sample is included. Latches clear on the edge ending the step cycle.
- **Resolution at step.** The following values are registered into the outputs at the edge that starts the step cycle+1. Equivalently, the outputs are registered and `step` is high in the cycle after `fcnt` wraps.
  - `right`/`left`: when both `lat_right` and `lat_left` are set, both commands are 0. Otherwise each passes through. Both are forced 0 while the defend FSM is ACTIVE.
  - `jump`: asserted when `lat_jump`=1, `prev_jump`=0, and defend is not ACTIVE. `prev_jump` holds `lat_jump` from the previous step, so a held button jumps once.
  - `squat`: equals `lat_squat` AND NOT `jump`. Jump wins a simultaneous request.
  - `defend`: equals 1 exactly when the FSM is ACTIVE after this step's transition.
- **Defend FSM.** Evaluated once per step using `lat_defend`. `dcnt` is a frame counter.
  - READY: if `lat_defend`=1, go to ACTIVE with `dcnt`=1.
  - ACTIVE:
    - `lat_defend`=0, or `dcnt`==DEF_MAX: go to COOL with `dcnt`=0.
    - Otherwise: `dcnt`+1.
  - COOL:
    - `dcnt`+1 each step.
    - When `dcnt`≥DEF_COOL-1 and `lat_defend`=0: go to READY.
    - A held button keeps the FSM in COOL (saturate `dcnt`) until it is released.
- `dcnt` width is `$clog2(max(DEF_MAX,DEF_COOL)+1)`. `fcnt` width is `$clog2(FRAME_DIV)`. All counters are unsigned with no overflow.

## Timing
- Reset values: `fcnt`=0, all latches 0, `prev_jump`=0, FSM=READY, `dcnt`=0. Outputs: `step`=0, all commands 0, `def_ready`=1.
- `step` period is exactly FRAME_DIV cycles. The first `step` occurs FRAME_DIV cycles after reset release.
- Latency: a key press is reflected at the next `step`. The worst case is FRAME_DIV cycles.
- A press held for 1 cycle anywhere within a frame window, including the step cycle, is never lost.
- Reset asserted mid-frame or mid-ACTIVE/COOL returns everything to reset values immediately. No command is emitted for the interrupted frame.
- Commands are never asserted outside `step`.

## Structure
- GamePkg gets the following, shared with `Player` and the top level:
  - `FRAME_DIV`, `DEF_MAX`, `DEF_COOL` defaults.
  - `typedef enum logic [1:0] {DEF_READY, DEF_ACTIVE, DEF_COOL} def_state_e`.
- One sub-module, `frame_tick`: parameterised divider with a `tick` output. It is reused by the renderer's animation timer.
- Resolution logic and the FSM stay inline.

## Test plan
Run with FRAME_DIV=4, DEF_MAX=3, DEF_COOL=2.
- **Reset.** Release reset, no keys → `step` at cycles 4, 8, 12 after release. All commands 0. `def_ready`=1.
- **Short press and conflict.** `key_right` 1-cycle pulse mid-frame → `right`=1 at next `step` only. `key_right`+`key_left` in the same frame → both 0.
- **Jump edge.** `key_jump` held 3 frames → `jump`=1 on the first `step` only. `key_jump`+`key_squat` in the same frame → `jump`=1, `squat`=0.
- **Defend budget.** `key_defend` held continuously → `defend`=1 for 3 steps. Then COOL: `defend`=0 and `right` is still blocked? No: `right` passes during COOL. Stays in COOL while held. Release → READY after 2 COOL steps.
- **Reset mid-operation.** Assert `rst` during ACTIVE with `key_right` latched → outputs 0, `def_ready`=1. The next `step` occurs 4 cycles after release and carries no stale `right`.
